// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round count, Rcon table and
// the RotWord helper used by the key schedule.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READY = 3'd1;
  localparam state_t ST_SUB   = 3'd2;
  localparam state_t ST_W0    = 3'd3;
  localparam state_t ST_W1    = 3'd4;
  localparam state_t ST_W2    = 3'd5;
  localparam state_t ST_W3    = 3'd6;

  localparam logic [7:0] RCON_TABLE [0:AES_NR-1] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Request/response bundle between the AES round controller (master) and the
// key expander (slave).
interface aes_key_expander_if;

  logic         en;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         next_key;
  logic [7:0]   rcon;
  logic [127:0] round_key;
  logic         Key_flag;
  logic         busy;
  logic [3:0]   round_cnt;

  modport master (
    output en, key_load, cipher_key, next_key, rcon,
    input  round_key, Key_flag, busy, round_cnt
  );

  modport slave (
    input  en, key_load, cipher_key, next_key, rcon,
    output round_key, Key_flag, busy, round_cnt
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Index 0 is the first entry listed.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expander.sv
// Word-serial AES-128 key schedule: one SubWord cycle then one word per cycle,
// publishing a complete round key only when all four words are done.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic                clk,
  input  logic                rst,
  aes_key_expander_if.slave   bus
);

  localparam logic [3:0] MAX_CNT = 4'(NUM_ROUNDS);

  state_t       r_state;
  logic [127:0] r_round_key;
  logic [31:0]  r_work [4];
  logic [31:0]  r_temp;
  logic [7:0]   r_rcon_q;
  logic [3:0]   r_round_cnt;
  logic         r_key_flag;

  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic         w_busy;

  assign w_rot = rot_word(r_work[3]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  assign w_busy = (r_state == ST_SUB) || (r_state == ST_W0) || (r_state == ST_W1) ||
                  (r_state == ST_W2)  || (r_state == ST_W3);

  always_ff @(posedge clk) begin
    r_key_flag <= 1'b0;
    if (rst) begin
      r_state     <= ST_IDLE;
      r_round_key <= '0;
      r_temp      <= '0;
      r_rcon_q    <= '0;
      r_round_cnt <= '0;
      for (int i = 0; i < 4; i++) r_work[i] <= '0;
    end else if (!bus.en) begin
      r_state     <= ST_IDLE;
      r_round_cnt <= '0;
    end else if (bus.key_load) begin
      r_round_key <= bus.cipher_key;
      r_round_cnt <= '0;
      r_key_flag  <= 1'b1;
      r_state     <= ST_READY;
    end else begin
      case (r_state)
        ST_READY: begin
          if (bus.next_key && (r_round_cnt < MAX_CNT)) begin
            r_rcon_q <= bus.rcon;
            r_work[0] <= r_round_key[127:96];
            r_work[1] <= r_round_key[95:64];
            r_work[2] <= r_round_key[63:32];
            r_work[3] <= r_round_key[31:0];
            r_state  <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_temp  <= w_sub ^ {r_rcon_q, 24'h0};
          r_state <= ST_W0;
        end
        ST_W0: begin
          r_work[0] <= r_work[0] ^ r_temp;
          r_state   <= ST_W1;
        end
        ST_W1: begin
          r_work[1] <= r_work[1] ^ r_work[0];
          r_state   <= ST_W2;
        end
        ST_W2: begin
          r_work[2] <= r_work[2] ^ r_work[1];
          r_state   <= ST_W3;
        end
        ST_W3: begin
          // Last word is folded straight into the published key.
          r_work[3]   <= r_work[3] ^ r_work[2];
          r_round_key <= {r_work[0], r_work[1], r_work[2], r_work[3] ^ r_work[2]};
          r_round_cnt <= (r_round_cnt < MAX_CNT) ? r_round_cnt + 4'd1 : r_round_cnt;
          r_key_flag  <= 1'b1;
          r_state     <= ST_READY;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.round_key = r_round_key;
  assign bus.Key_flag  = r_key_flag;
  assign bus.busy      = w_busy;
  assign bus.round_cnt = r_round_cnt;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key schedule vectors.
module tb_aes_key_expander;
  import aes_pkg::*;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass = 0;

  aes_key_expander_if bus_if ();

  aes_key_expander #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, counting Key_flag pulses and cycles where flag and busy coincide.
  task automatic watch(input int n, output int flags, output int overlap);
    flags = 0;
    overlap = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus_if.Key_flag) flags++;
      if (bus_if.Key_flag && bus_if.busy) overlap++;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    bus_if.key_load = 1'b1;
    bus_if.cipher_key = key;
    step();
    bus_if.key_load = 1'b0;
    $display("load key=%h flag=%0d cnt=%0d", key, bus_if.Key_flag, bus_if.round_cnt);
  endtask

  // Issue one request and return cycles from request to Key_flag (bounded).
  task automatic request(input logic [7:0] rc, output int lat);
    bus_if.next_key = 1'b1;
    bus_if.rcon = rc;
    step();
    bus_if.next_key = 1'b0;
    lat = 1;
    while (!bus_if.Key_flag && lat < 20) begin
      step();
      lat++;
    end
    $display("request rcon=%h latency=%0d key=%h cnt=%0d busy=%0d",
             rc, lat, bus_if.round_key, bus_if.round_cnt, bus_if.busy);
  endtask

  initial begin
    int lat;
    int flags;
    int overlap;
    logic [127:0] held;

    rst = 1'b1;
    bus_if.en = 1'b0;
    bus_if.key_load = 1'b0;
    bus_if.cipher_key = '0;
    bus_if.next_key = 1'b0;
    bus_if.rcon = '0;
    step();
    step();
    check("rst_round_key", bus_if.round_key, '0);
    check("rst_flag", 128'(bus_if.Key_flag), 128'd0);
    check("rst_busy", 128'(bus_if.busy), 128'd0);
    check("rst_cnt", 128'(bus_if.round_cnt), 128'd0);
    rst = 1'b0;
    bus_if.en = 1'b1;

    // Request in IDLE is ignored.
    bus_if.next_key = 1'b1;
    bus_if.rcon = 8'h01;
    step();
    bus_if.next_key = 1'b0;
    check("idle_busy", 128'(bus_if.busy), 128'd0);
    watch(8, flags, overlap);
    $display("idle request flags=%0d", flags);
    check("idle_flags", 128'(flags), 128'd0);

    load_key(KEY_A);
    check("load_flag", 128'(bus_if.Key_flag), 128'd1);
    check("load_key", bus_if.round_key, KEY_A);
    check("load_cnt", 128'(bus_if.round_cnt), 128'd0);
    step();
    check("load_flag_width", 128'(bus_if.Key_flag), 128'd0);

    request(8'h01, lat);
    check("r1_latency", 128'(lat), 128'd6);
    check("r1_key", bus_if.round_key, KEY_A_R1);
    check("r1_cnt", 128'(bus_if.round_cnt), 128'd1);
    check("r1_busy", 128'(bus_if.busy), 128'd0);

    for (int r = 1; r < AES_NR; r++) begin
      request(RCON_TABLE[r], lat);
      check("sched_latency", 128'(lat), 128'd6);
    end
    check("r10_key", bus_if.round_key, KEY_A_R10);
    check("r10_cnt", 128'(bus_if.round_cnt), 128'd10);

    // Eleventh request at the saturation limit.
    bus_if.next_key = 1'b1;
    bus_if.rcon = 8'h36;
    step();
    bus_if.next_key = 1'b0;
    check("sat_busy", 128'(bus_if.busy), 128'd0);
    watch(8, flags, overlap);
    $display("request at limit flags=%0d cnt=%0d", flags, bus_if.round_cnt);
    check("sat_flags", 128'(flags), 128'd0);
    check("sat_cnt", 128'(bus_if.round_cnt), 128'd10);
    check("sat_key", bus_if.round_key, KEY_A_R10);

    // Extra requests while busy and rcon scrambled after acceptance.
    load_key(KEY_A);
    bus_if.next_key = 1'b1;
    bus_if.rcon = 8'h01;
    step();
    flags = 0;
    overlap = 0;
    for (int i = 1; i <= 11; i++) begin
      bus_if.next_key = (i <= 4);
      bus_if.rcon = 8'hff;
      step();
      if (bus_if.Key_flag) flags++;
      if (bus_if.Key_flag && bus_if.busy) overlap++;
    end
    bus_if.next_key = 1'b0;
    $display("busy pulses flags=%0d key=%h cnt=%0d", flags, bus_if.round_key, bus_if.round_cnt);
    check("busy_flags", 128'(flags), 128'd1);
    check("busy_overlap", 128'(overlap), 128'd0);
    check("rcon_late_key", bus_if.round_key, KEY_A_R1);
    check("busy_cnt", 128'(bus_if.round_cnt), 128'd1);

    // Abort by load in W2.
    load_key(KEY_A);
    bus_if.next_key = 1'b1;
    bus_if.rcon = 8'h01;
    step();
    bus_if.next_key = 1'b0;
    step();
    step();
    step();
    check("w2_busy", 128'(bus_if.busy), 128'd1);
    load_key(KEY_B);
    check("abort_load_flag", 128'(bus_if.Key_flag), 128'd1);
    check("abort_load_key", bus_if.round_key, KEY_B);
    check("abort_load_cnt", 128'(bus_if.round_cnt), 128'd0);
    watch(8, flags, overlap);
    $display("after load abort flags=%0d", flags);
    check("abort_load_noflag", 128'(flags), 128'd0);
    check("abort_load_key_hold", bus_if.round_key, KEY_B);
    request(8'h01, lat);
    check("b_r1_latency", 128'(lat), 128'd6);
    check("b_r1_key", bus_if.round_key, KEY_B_R1);

    // Abort by enable in W1.
    held = bus_if.round_key;
    bus_if.next_key = 1'b1;
    bus_if.rcon = 8'h02;
    step();
    bus_if.next_key = 1'b0;
    step();
    step();
    bus_if.en = 1'b0;
    step();
    $display("enable drop busy=%0d cnt=%0d key=%h", bus_if.busy, bus_if.round_cnt, bus_if.round_key);
    check("en_busy", 128'(bus_if.busy), 128'd0);
    check("en_cnt", 128'(bus_if.round_cnt), 128'd0);
    check("en_key_hold", bus_if.round_key, held);
    check("en_flag", 128'(bus_if.Key_flag), 128'd0);
    bus_if.en = 1'b1;
    watch(8, flags, overlap);
    check("en_noflag", 128'(flags), 128'd0);
    bus_if.next_key = 1'b1;
    bus_if.rcon = 8'h01;
    step();
    bus_if.next_key = 1'b0;
    check("en_idle_busy", 128'(bus_if.busy), 128'd0);
    watch(8, flags, overlap);
    $display("request after enable drop flags=%0d", flags);
    check("en_idle_flags", 128'(flags), 128'd0);
    check("en_idle_key", bus_if.round_key, held);
    load_key(KEY_A);
    check("reload_key", bus_if.round_key, KEY_A);
    check("reload_flag", 128'(bus_if.Key_flag), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
